// File: rtl/modulation_pkg.sv
// Shared definitions for the modulation scheduler.
//   state_t         : scheduler FSM states
//   READ_LATENCY    : cycles from MOD_ADDR to valid MOD_DATA
//   DEFAULT_TIMEOUT : default multiplier completion budget
//   (the timeout feature itself is enabled by MODULATION_TIMEOUT_EN)
package modulation_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StStart,
        StWaitDone,
        StFinish
    } state_t;

    localparam int unsigned READ_LATENCY    = 2;
    localparam int unsigned DEFAULT_TIMEOUT = 512;

endpackage

// File: rtl/modulation_index_counter.sv
// Sample index counter for the modulation scheduler.
// Counts completed steps in div_cnt and advances the sample index once every
// max(FREQ_DIV,1) steps, wrapping to 0 at or beyond the cycle length.
// Ports:
//   i_clk      : clock
//   i_rst      : synchronous active-high reset
//   i_advance  : one-cycle strobe, one completed step
//   i_cycle    : last valid buffer index, sampled only with i_advance
//   i_freq_div : steps per sample (0 means 1), sampled only with i_advance
//   o_idx      : current sample index
module modulation_index_counter #(
    parameter int unsigned ADDR_WIDTH = 15
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_advance,
    input  logic [ADDR_WIDTH-1:0] i_cycle,
    input  logic [31:0]           i_freq_div,
    output logic [ADDR_WIDTH-1:0] o_idx
);

    logic [31:0]           r_div_cnt;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [31:0]           w_div_last;
    logic [ADDR_WIDTH-1:0] w_idx_next;

    // >= rather than == so a FREQ_DIV reduced below the running count still rolls over
    assign w_div_last = (i_freq_div == 32'd0) ? 32'd0 : (i_freq_div - 32'd1);
    assign w_idx_next = (r_idx >= i_cycle) ? '0 : (r_idx + 1'b1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div_cnt <= 32'd0;
            r_idx     <= '0;
        end else if (i_advance) begin
            if (r_div_cnt >= w_div_last) begin
                r_div_cnt <= 32'd0;
                r_idx     <= w_idx_next;
            end else begin
                r_div_cnt <= r_div_cnt + 32'd1;
            end
        end
    end

    assign o_idx = r_idx;

endmodule

// File: rtl/modulation_scheduler.sv
// Modulation scheduler: on each UPDATE pulse, fetches the modulation factor
// for the current sample index, hands it to an external multiplier, waits for
// completion and reports DUTY_VALID, then advances the index via the divider.
// Optional macro MODULATION_TIMEOUT_EN: abort WAIT_DONE after TIMEOUT cycles
// and raise TIMEOUT_ERR; without it TIMEOUT_ERR is tied 0.
// Ports:
//   CLK, RST      : clock, synchronous active-high reset
//   UPDATE        : step request pulse
//   CYCLE         : last valid buffer index
//   FREQ_DIV      : steps per sample (0 means 1)
//   MOD_ADDR      : registered buffer read address (tracks IDX)
//   MOD_DATA      : buffer read data, READ_LATENCY cycles after MOD_ADDR
//   MULT_START    : multiplier start pulse
//   MULT_M        : modulation factor to the multiplier
//   MULT_DONE     : multiplier completion pulse
//   DUTY_VALID    : scaled duties ready pulse
//   IDX           : current sample index
//   OVERRUN       : sticky, UPDATE seen while busy
//   TIMEOUT_ERR   : sticky, multiplier timed out
//   CLR_FLAGS     : clears the sticky flags (a same-cycle set wins)
module modulation_scheduler
    import modulation_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  UPDATE,
    input  logic [ADDR_WIDTH-1:0] CYCLE,
    input  logic [31:0]           FREQ_DIV,
    output logic [ADDR_WIDTH-1:0] MOD_ADDR,
    input  logic [7:0]            MOD_DATA,
    output logic                  MULT_START,
    output logic [7:0]            MULT_M,
    input  logic                  MULT_DONE,
    output logic                  DUTY_VALID,
    output logic [ADDR_WIDTH-1:0] IDX,
    output logic                  OVERRUN,
    output logic                  TIMEOUT_ERR,
    input  logic                  CLR_FLAGS
);

    localparam logic [1:0] FetchLast = 2'(READ_LATENCY - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [1:0]            r_fetch_cnt;
    logic [ADDR_WIDTH-1:0] r_mod_addr;
    logic [7:0]            r_mult_m;
    logic                  r_overrun;
    logic                  w_overrun_set;
    logic                  w_timeout;
    logic                  w_advance;
    logic [ADDR_WIDTH-1:0] w_idx;

    assign w_overrun_set = UPDATE && (r_state != StIdle);
    assign w_advance     = (r_state == StFinish);

`ifdef MODULATION_TIMEOUT_EN
    logic [31:0] r_to_cnt;
    logic        r_timeout_err;

    // r_to_cnt holds the number of cycles since MULT_START while in WAIT_DONE
    assign w_timeout = (r_state == StWaitDone) && !MULT_DONE &&
                       (r_to_cnt >= 32'(TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_to_cnt      <= 32'd0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == StStart) begin
                r_to_cnt <= 32'd1;
            end else if (r_state == StWaitDone) begin
                r_to_cnt <= r_to_cnt + 32'd1;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end else if (CLR_FLAGS) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    assign TIMEOUT_ERR = r_timeout_err;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^TIMEOUT;
    assign w_timeout        = 1'b0;
    assign TIMEOUT_ERR      = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= StIdle;
            r_fetch_cnt <= 2'd0;
            r_mod_addr  <= '0;
            r_mult_m    <= 8'd0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_fetch_cnt <= (r_state == StFetch) ? (r_fetch_cnt + 2'd1) : 2'd0;
            r_mod_addr  <= w_idx;
            if (r_state == StStart) begin
                r_mult_m <= MOD_DATA;
            end
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (CLR_FLAGS) begin
                r_overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:     if (UPDATE) w_state_next = StFetch;
            StFetch:    if (r_fetch_cnt == FetchLast) w_state_next = StStart;
            StStart:    w_state_next = StWaitDone;
            StWaitDone: begin
                if (MULT_DONE) begin
                    w_state_next = StFinish;
                end else if (w_timeout) begin
                    w_state_next = StIdle;
                end
            end
            StFinish:   w_state_next = StIdle;
            default:    w_state_next = StIdle;
        endcase
    end

    modulation_index_counter #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_index_counter (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_advance  (w_advance),
        .i_cycle    (CYCLE),
        .i_freq_div (FREQ_DIV),
        .o_idx      (w_idx)
    );

    assign MOD_ADDR   = r_mod_addr;
    assign MULT_START = (r_state == StStart);
    assign MULT_M     = r_mult_m;
    assign DUTY_VALID = (r_state == StFinish);
    assign IDX        = w_idx;
    assign OVERRUN    = r_overrun;

endmodule

// File: tb/tb_modulation_scheduler.sv
// Directed self-checking bench for modulation_scheduler.
module tb_modulation_scheduler;
    import modulation_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        UPDATE = 1'b0;
    logic [14:0] CYCLE = 15'd3;
    logic [31:0] FREQ_DIV = 32'd1;
    logic [14:0] MOD_ADDR;
    logic [7:0]  MOD_DATA;
    logic        MULT_START;
    logic [7:0]  MULT_M;
    logic        MULT_DONE = 1'b0;
    logic        DUTY_VALID;
    logic [14:0] IDX;
    logic        OVERRUN;
    logic        TIMEOUT_ERR;
    logic        CLR_FLAGS = 1'b0;

    int total = 0;
    int bad = 0;
    int dv_count = 0;
    int dv0;
    logic [7:0] r_d1;

    modulation_scheduler #(
        .ADDR_WIDTH (15),
        .TIMEOUT    (512)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .UPDATE      (UPDATE),
        .CYCLE       (CYCLE),
        .FREQ_DIV    (FREQ_DIV),
        .MOD_ADDR    (MOD_ADDR),
        .MOD_DATA    (MOD_DATA),
        .MULT_START  (MULT_START),
        .MULT_M      (MULT_M),
        .MULT_DONE   (MULT_DONE),
        .DUTY_VALID  (DUTY_VALID),
        .IDX         (IDX),
        .OVERRUN     (OVERRUN),
        .TIMEOUT_ERR (TIMEOUT_ERR),
        .CLR_FLAGS   (CLR_FLAGS)
    );

    always #5 CLK = ~CLK;

    // Buffer model: data = addr*10, two-cycle read latency
    always @(posedge CLK) begin
        r_d1     <= 8'(MOD_ADDR * 10);
        MOD_DATA <= r_d1;
    end

    always @(posedge CLK) begin
        if (DUTY_VALID === 1'b1) dv_count <= dv_count + 1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    // One full step; MULT_DONE comes dly cycles after the MULT_START cycle.
    task automatic step(input int dly, input logic [7:0] exp_m, input logic [14:0] exp_idx,
                        input int chg_cycle);
        int d0;
        tick();
        UPDATE = 1'b1;
        tick();
        UPDATE = 1'b0;
        chk("fetch_state", 32'(dut.r_state), 32'(StFetch));
        chk("start_lo_t1", 32'(MULT_START), 32'd0);
        tick();
        chk("start_lo_t2", 32'(MULT_START), 32'd0);
        tick();
        chk("start_pulse_t3", 32'(MULT_START), 32'd1);
        d0 = dv_count;
        tick();
        chk("mult_m", 32'(MULT_M), 32'(exp_m));
        chk("start_lo_t4", 32'(MULT_START), 32'd0);
        if (chg_cycle >= 0) CYCLE = 15'(chg_cycle);
        repeat (dly - 1) tick();
        MULT_DONE = 1'b1;
        tick();
        MULT_DONE = 1'b0;
        chk("duty_valid", 32'(DUTY_VALID), 32'd1);
        tick();
        chk("duty_once", 32'(dv_count - d0), 32'd1);
        chk("idx", 32'(IDX), 32'(exp_idx));
        chk("idle_after", 32'(dut.r_state), 32'(StIdle));
    endtask

    initial begin
        // Reset values
        do_reset();
        chk("rst_idx", 32'(IDX), 32'd0);
        chk("rst_addr", 32'(MOD_ADDR), 32'd0);
        chk("rst_m", 32'(MULT_M), 32'd0);
        chk("rst_start", 32'(MULT_START), 32'd0);
        chk("rst_dv", 32'(DUTY_VALID), 32'd0);
        chk("rst_ovr", 32'(OVERRUN), 32'd0);
        chk("rst_to", 32'(TIMEOUT_ERR), 32'd0);
        chk("rst_state", 32'(dut.r_state), 32'(StIdle));

        // Stray MULT_DONE in IDLE is ignored
        MULT_DONE = 1'b1;
        tick();
        MULT_DONE = 1'b0;
        tick();
        chk("stray_done_dv", 32'(dv_count), 32'd0);
        chk("stray_done_state", 32'(dut.r_state), 32'(StIdle));

        // FREQ_DIV=1, CYCLE=3
        FREQ_DIV = 32'd1;
        CYCLE    = 15'd3;
        step(37, 8'd0,  15'd1, -1);
        step(37, 8'd10, 15'd2, -1);
        step(37, 8'd20, 15'd3, -1);
        step(37, 8'd30, 15'd0, -1);
        step(37, 8'd0,  15'd1, -1);

        // FREQ_DIV=3, CYCLE=1: advance after steps 3 and 6
        do_reset();
        FREQ_DIV = 32'd3;
        CYCLE    = 15'd1;
        step(4, 8'd0,  15'd0, -1);
        step(4, 8'd0,  15'd0, -1);
        step(4, 8'd0,  15'd1, -1);
        step(4, 8'd10, 15'd1, -1);
        step(4, 8'd10, 15'd1, -1);
        step(4, 8'd10, 15'd0, -1);
        step(4, 8'd0,  15'd0, -1);
        chk("div_cnt_end", dut.u_index_counter.r_div_cnt, 32'd1);

        // FREQ_DIV=0 behaves as 1
        FREQ_DIV = 32'd0;
        step(2, 8'd0, 15'd1, -1);

        // Overrun: second UPDATE 5 cycles after the first is dropped
        do_reset();
        FREQ_DIV = 32'd1;
        CYCLE    = 15'd3;
        dv0 = dv_count;
        tick();
        UPDATE = 1'b1;
        tick();
        UPDATE = 1'b0;
        repeat (4) tick();
        UPDATE = 1'b1;
        tick();
        UPDATE = 1'b0;
        chk("ovr_set", 32'(OVERRUN), 32'd1);
        MULT_DONE = 1'b1;
        tick();
        MULT_DONE = 1'b0;
        repeat (12) tick();
        chk("ovr_one_dv", 32'(dv_count - dv0), 32'd1);
        chk("ovr_idx", 32'(IDX), 32'd1);
        chk("ovr_idle", 32'(dut.r_state), 32'(StIdle));
        CLR_FLAGS = 1'b1;
        tick();
        CLR_FLAGS = 1'b0;
        chk("ovr_clr", 32'(OVERRUN), 32'd0);
        // Busy UPDATE and CLR_FLAGS together: set wins
        tick();
        UPDATE = 1'b1;
        tick();
        CLR_FLAGS = 1'b1;
        tick();
        UPDATE    = 1'b0;
        CLR_FLAGS = 1'b0;
        chk("ovr_set_wins", 32'(OVERRUN), 32'd1);
        repeat (2) tick();
        MULT_DONE = 1'b1;
        tick();
        MULT_DONE = 1'b0;
        tick();
        chk("ovr_idx2", 32'(IDX), 32'd2);

        // IDX=5 then CYCLE reduced to 2 mid-step wraps to 0
        do_reset();
        FREQ_DIV = 32'd1;
        CYCLE    = 15'd7;
        step(3, 8'd0,  15'd1, -1);
        step(3, 8'd10, 15'd2, -1);
        step(3, 8'd20, 15'd3, -1);
        step(3, 8'd30, 15'd4, -1);
        step(3, 8'd40, 15'd5, -1);
        step(3, 8'd50, 15'd0, 2);

        // Timeout behaviour
        do_reset();
        CYCLE = 15'd3;
        dv0 = dv_count;
        tick();
        UPDATE = 1'b1;
        tick();
        UPDATE = 1'b0;
        repeat (2) tick();
        chk("to_start", 32'(MULT_START), 32'd1);
`ifdef MODULATION_TIMEOUT_EN
        repeat (511) tick();
        chk("to_before", 32'(TIMEOUT_ERR), 32'd0);
        chk("to_before_state", 32'(dut.r_state), 32'(StWaitDone));
        tick();
        chk("to_err", 32'(TIMEOUT_ERR), 32'd1);
        chk("to_idle", 32'(dut.r_state), 32'(StIdle));
        chk("to_idx", 32'(IDX), 32'd0);
        chk("to_no_dv", 32'(dv_count - dv0), 32'd0);
        CLR_FLAGS = 1'b1;
        tick();
        CLR_FLAGS = 1'b0;
        chk("to_clr", 32'(TIMEOUT_ERR), 32'd0);
`else
        repeat (600) tick();
        chk("to_none", 32'(TIMEOUT_ERR), 32'd0);
        chk("to_still_wait", 32'(dut.r_state), 32'(StWaitDone));
        MULT_DONE = 1'b1;
        tick();
        MULT_DONE = 1'b0;
        chk("to_late_dv", 32'(DUTY_VALID), 32'd1);
        tick();
        chk("to_late_idx", 32'(IDX), 32'd1);
`endif

        // RST in WAIT_DONE, MULT_DONE 2 cycles later
        do_reset();
        FREQ_DIV = 32'd1;
        CYCLE    = 15'd3;
        step(3, 8'd0,  15'd1, -1);
        step(3, 8'd10, 15'd2, -1);
        dv0 = dv_count;
        tick();
        UPDATE = 1'b1;
        tick();
        UPDATE = 1'b0;
        repeat (3) tick();
        chk("rst_mid_wait", 32'(dut.r_state), 32'(StWaitDone));
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tick();
        MULT_DONE = 1'b1;
        tick();
        MULT_DONE = 1'b0;
        repeat (3) tick();
        chk("rstm_state", 32'(dut.r_state), 32'(StIdle));
        chk("rstm_idx", 32'(IDX), 32'd0);
        chk("rstm_addr", 32'(MOD_ADDR), 32'd0);
        chk("rstm_m", 32'(MULT_M), 32'd0);
        chk("rstm_start", 32'(MULT_START), 32'd0);
        chk("rstm_ovr", 32'(OVERRUN), 32'd0);
        chk("rstm_to", 32'(TIMEOUT_ERR), 32'd0);
        chk("rstm_no_dv", 32'(dv_count - dv0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
